wasm_instr_loader: RTL and testbench
====================================

Name: wasm_instr_loader

Overview:
Write-side companion to the instruction memory controller. It accepts a WASM module as a byte stream, optionally checks and strips the 8-byte module header, and packs body bytes into write windows. It then drives the instruction memory write port: we, write_pointer_shift_minusone, wr_data. It holds the core via busy while loading, and reports completion or error.

Parameters:
WR_BYTES, 8, bytes per write window; wr_data width = 8*WR_BYTES.
LOG_WIN, 3, log2(WR_BYTES); width of write_pointer_shift_minusone.
CHECK_HDR, 1, 1 = check and strip header 00 61 73 6D 01 00 00 00; 0 = every byte is body.
MAX_BYTES, 1024, instruction memory capacity in bytes.
CNT_W, 16, width of byte_cnt; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle load request; ignored unless state is IDLE.
s_valid  in  1  stream byte valid.
s_data  in  8  stream byte.
s_last  in  1  marks the final byte of the module.
s_ready  out  1  loader accepts the byte this cycle.
we  out  1  write request to instruction memory.
write_pointer_shift_minusone  out  LOG_WIN  number of valid bytes in wr_data, minus 1.
wr_data  out  8*WR_BYTES  packed window; first byte in bits [7:0].
wr_ready  in  1  memory accepts the write this cycle.
busy  out  1  load in progress; core must stay halted while high.
done  out  1  one-cycle pulse on successful completion.
hdr_error  out  1  sticky; header mismatch or premature s_last.
ovf_error  out  1  sticky; body larger than MAX_BYTES.
byte_cnt  out  CNT_W  body bytes accepted in the current or last load.

Behaviour:
- A byte transfers when s_valid and s_ready are both high. A write completes when we and wr_ready are both high.
- Reset, from any state including mid-load: state IDLE; all outputs 0; pack register, index and byte_cnt cleared. No partial window is written.
- States: IDLE, HDR, BODY, WRITE, ERR.
- IDLE: s_ready=0, busy=0.
  - start=1 clears hdr_error, ovf_error and byte_cnt.
  - Next state is HDR when CHECK_HDR=1, otherwise BODY.
  - busy=1 from the next cycle onward.
- HDR: s_ready=1; a 3-bit header index counts 0..7.
  - Each accepted byte is compared to the expected header byte.
  - Any mismatch, or s_last on index 0..6: set hdr_error and go to ERR. If the byte was s_last, go to IDLE instead.
  - Index 7 matching without s_last: go to BODY.
  - Index 7 matching with s_last (empty body): done pulses next cycle, go to IDLE, no write issued.
- BODY: s_ready=1.
  - Accepted byte k of the window is stored at bits [8k+7:8k]; byte_cnt increments.
  - If the byte would make byte_cnt exceed MAX_BYTES, it is dropped: set ovf_error, go to ERR, or to IDLE if it was s_last.
  - Window fills (k = WR_BYTES-1) or s_last accepted: go to WRITE, latching the last flag.
- WRITE: s_ready=0, we=1.
  - wr_data and write_pointer_shift_minusone (count-1) are held stable until wr_ready.
  - Unused upper bytes are zero.
  - On handshake: the pack register clears. If the last flag is set, go to IDLE and pulse done for one cycle in the IDLE-entry cycle (busy=0 that cycle). Otherwise go to BODY.
  - At most one write is issued per window.
- ERR: s_ready=1, busy=1, we=0.
  - Bytes are discarded until s_last is accepted, then go to IDLE.
  - Error flags stay set and done does not pulse.
- start while busy: ignored. s_last with s_valid=0: ignored.
- Latency: the last byte of a window is accepted in cycle N; we=1 in N+1. With wr_ready tied high, s_ready returns in N+2, giving a throughput of WR_BYTES bytes per WR_BYTES+1 cycles.
- byte_cnt holds its final value in IDLE until the next start.

Test Plan:
- Default params: start, then header plus body bytes 0x01..0x0A with s_last on 0x0A, wr_ready=1. Expected: write 1 has wr_data=0x0807060504030201, shift_minusone=7. Write 2 has wr_data=0x0000000000000A09, shift_minusone=1. Then done pulses once, byte_cnt=10, busy=0.
- Header byte 3 = 0x6E instead of 0x6D, followed by 4 more bytes with s_last. Expected: hdr_error=1, s_ready=1 throughout, we never asserted, returns to IDLE after s_last, done=0.
- Header only, s_last on byte 8. Expected: no write, done pulses, byte_cnt=0.
- MAX_BYTES=8, body of 10 bytes. Expected: one full write of 8 bytes; byte 9 sets ovf_error; byte 10 (last) drained; byte_cnt=8; no done.
- wr_ready held low for 5 cycles during a write. Expected: we, wr_data and shift_minusone stable all 5 cycles, s_ready=0, exactly one write completes.
- rst asserted mid-BODY after 3 body bytes, then a fresh start with a valid module. Expected: all outputs 0 after reset, the 3 stale bytes are never written, and the new load completes correctly.

Source files
------------

// File: rtl/wasm_instr_loader.sv
// wasm_instr_loader
// Accepts a WASM module as a byte stream, optionally checks and strips the
// 8-byte module header, packs body bytes into WR_BYTES-wide write windows
// and drives the instruction memory write port. busy holds the core halted
// for the whole load; done / hdr_error / ovf_error report the outcome.
module wasm_instr_loader #(
    parameter int WR_BYTES  = 8,
    parameter int LOG_WIN   = 3,
    parameter int CHECK_HDR = 1,
    parameter int MAX_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic                    we,
    output logic [LOG_WIN-1:0]      write_pointer_shift_minusone,
    output logic [8*WR_BYTES-1:0]   wr_data,
    input  logic                    wr_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    hdr_error,
    output logic                    ovf_error,
    output logic [CNT_W-1:0]        byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_BODY  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Expected WASM magic + version: 00 61 73 6D 01 00 00 00
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd1:    b = 8'h61;
            3'd2:    b = 8'h73;
            3'd3:    b = 8'h6D;
            3'd4:    b = 8'h01;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic [2:0]              hdr_idx_r;
    logic [LOG_WIN-1:0]      win_idx_r;
    logic [LOG_WIN-1:0]      len_r;
    logic [8*WR_BYTES-1:0]   pack_r;
    logic                    last_r;
    logic [CNT_W-1:0]        byte_cnt_r;
    logic                    s_ready_r;
    logic                    we_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    hdr_err_r;
    logic                    ovf_err_r;

    logic                    xfer_s;
    logic                    wdone_s;
    logic                    cnt_full_s;
    logic                    win_end_s;
    logic                    load_start_s;
    logic                    hdr_adv_s;
    logic                    body_store_s;
    logic                    set_hdr_err_s;
    logic                    set_ovf_err_s;
    logic                    done_set_s;
    logic                    win_clr_s;

    assign xfer_s     = s_valid & s_ready_r;
    assign wdone_s    = we_r & wr_ready;
    assign cnt_full_s = (byte_cnt_r == CNT_W'(MAX_BYTES));
    assign win_end_s  = (win_idx_r == LOG_WIN'(WR_BYTES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        state_s       = state_r;
        load_start_s  = 1'b0;
        hdr_adv_s     = 1'b0;
        body_store_s  = 1'b0;
        set_hdr_err_s = 1'b0;
        set_ovf_err_s = 1'b0;
        done_set_s    = 1'b0;
        win_clr_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    load_start_s = 1'b1;
                    state_s      = (CHECK_HDR != 0) ? S_HDR : S_BODY;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HDR: begin
                if (xfer_s) begin
                    if ((s_data != hdr_byte(hdr_idx_r)) ||
                        (s_last && (hdr_idx_r != 3'd7))) begin
                        set_hdr_err_s = 1'b1;
                        state_s       = s_last ? S_IDLE : S_ERR;
                    end else if (hdr_idx_r == 3'd7) begin
                        // Header-only module: finish without any write
                        done_set_s = s_last;
                        state_s    = s_last ? S_IDLE : S_BODY;
                    end else begin
                        hdr_adv_s = 1'b1;
                    end
                end else begin
                    state_s = S_HDR;
                end
            end
            S_BODY: begin
                if (xfer_s) begin
                    if (cnt_full_s) begin
                        // Byte would exceed memory capacity: drop it
                        set_ovf_err_s = 1'b1;
                        state_s       = s_last ? S_IDLE : S_ERR;
                    end else begin
                        body_store_s = 1'b1;
                        state_s      = (s_last || win_end_s) ? S_WRITE : S_BODY;
                    end
                end else begin
                    state_s = S_BODY;
                end
            end
            S_WRITE: begin
                if (wdone_s) begin
                    win_clr_s  = 1'b1;
                    done_set_s = last_r;
                    state_s    = last_r ? S_IDLE : S_BODY;
                end else begin
                    state_s = S_WRITE;
                end
            end
            S_ERR: begin
                if (xfer_s && s_last) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_ERR;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Registered outputs, packing window, counters and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_idx_r  <= 3'd0;
            win_idx_r  <= '0;
            len_r      <= '0;
            pack_r     <= '0;
            last_r     <= 1'b0;
            byte_cnt_r <= '0;
            s_ready_r  <= 1'b0;
            we_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hdr_err_r  <= 1'b0;
            ovf_err_r  <= 1'b0;
        end else begin
            s_ready_r <= (state_s == S_HDR) || (state_s == S_BODY) || (state_s == S_ERR);
            we_r      <= (state_s == S_WRITE);
            busy_r    <= (state_s != S_IDLE);
            done_r    <= done_set_s;
            if (load_start_s) begin
                hdr_idx_r  <= 3'd0;
                win_idx_r  <= '0;
                len_r      <= '0;
                pack_r     <= '0;
                last_r     <= 1'b0;
                byte_cnt_r <= '0;
                hdr_err_r  <= 1'b0;
                ovf_err_r  <= 1'b0;
            end else begin
                if (hdr_adv_s) begin
                    hdr_idx_r <= hdr_idx_r + 3'd1;
                end
                if (body_store_s) begin
                    pack_r[{win_idx_r, 3'b000} +: 8] <= s_data;
                    win_idx_r  <= win_idx_r + LOG_WIN'(1);
                    len_r      <= win_idx_r;
                    last_r     <= s_last;
                    byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                end
                if (win_clr_s) begin
                    pack_r    <= '0;
                    win_idx_r <= '0;
                end
                if (set_hdr_err_s) begin
                    hdr_err_r <= 1'b1;
                end
                if (set_ovf_err_s) begin
                    ovf_err_r <= 1'b1;
                end
            end
        end
    end

    assign s_ready                      = s_ready_r;
    assign we                           = we_r;
    assign write_pointer_shift_minusone = len_r;
    assign wr_data                      = pack_r;
    assign busy                         = busy_r;
    assign done                         = done_r;
    assign hdr_error                    = hdr_err_r;
    assign ovf_error                    = ovf_err_r;
    assign byte_cnt                     = byte_cnt_r;

endmodule

// File: tb/tb_wasm_instr_loader.sv
// Directed bench for wasm_instr_loader: one default instance (a) and one
// with MAX_BYTES=8 (b). Expected writes go into a queue when a module is
// streamed in; a negedge monitor pops and compares on each write handshake.
module tb_wasm_instr_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic        s_valid, s_last, wr_ready;
    logic [7:0]  s_data;

    logic        s_ready_a, we_a, busy_a, done_a, hdr_error_a, ovf_error_a;
    logic [2:0]  shm1_a;
    logic [63:0] wr_data_a;
    logic [15:0] byte_cnt_a;
    logic        s_ready_b, we_b, busy_b, done_b, hdr_error_b, ovf_error_b;
    logic [2:0]  shm1_b;
    logic [63:0] wr_data_b;
    logic [15:0] byte_cnt_b;

    wasm_instr_loader dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready_a),
        .we(we_a), .write_pointer_shift_minusone(shm1_a), .wr_data(wr_data_a),
        .wr_ready(wr_ready), .busy(busy_a), .done(done_a),
        .hdr_error(hdr_error_a), .ovf_error(ovf_error_a), .byte_cnt(byte_cnt_a)
    );

    wasm_instr_loader #(.MAX_BYTES(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready_b),
        .we(we_b), .write_pointer_shift_minusone(shm1_b), .wr_data(wr_data_b),
        .wr_ready(wr_ready), .busy(busy_b), .done(done_b),
        .hdr_error(hdr_error_b), .ovf_error(ovf_error_b), .byte_cnt(byte_cnt_b)
    );

    // Select which instance the stream and checks refer to
    logic        sel = 1'b0;
    logic        s_ready_m, we_m, busy_m, done_m, hdr_error_m, ovf_error_m;
    logic [2:0]  shm1_m;
    logic [63:0] wr_data_m;
    logic [15:0] byte_cnt_m;
    assign s_ready_m   = sel ? s_ready_b   : s_ready_a;
    assign we_m        = sel ? we_b        : we_a;
    assign busy_m      = sel ? busy_b      : busy_a;
    assign done_m      = sel ? done_b      : done_a;
    assign hdr_error_m = sel ? hdr_error_b : hdr_error_a;
    assign ovf_error_m = sel ? ovf_error_b : ovf_error_a;
    assign shm1_m      = sel ? shm1_b      : shm1_a;
    assign wr_data_m   = sel ? wr_data_b   : wr_data_a;
    assign byte_cnt_m  = sel ? byte_cnt_b  : byte_cnt_a;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  len;
    } wr_exp_t;
    wr_exp_t wq[$];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int wr_cnt = 0;

    logic [7:0] hdr [8] = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port scoreboard and done-pulse counter
    always @(negedge clk) begin
        if (!rst) begin
            if (we_m) begin
                chk("s_ready_during_write", {63'd0, s_ready_m}, 64'd0);
                if (wq.size() == 0) begin
                    chk("unexpected_write", {63'd0, we_m}, 64'd0);
                end else begin
                    chk("wr_data", wr_data_m, wq[0].data);
                    chk("shift_minusone", {61'd0, shm1_m}, {61'd0, wq[0].len});
                    if (wr_ready) begin
                        void'(wq.pop_front());
                        wr_cnt++;
                    end
                end
            end
            if (done_m) done_cnt++;
        end
    end

    task automatic send(input logic [7:0] d, input logic l, output int waited);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready_m && n < 50) begin
            n++;
            @(negedge clk);
        end
        waited = n;
        if (n >= 50) chk("send_timeout", {63'd0, s_ready_m}, 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_start();
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy_m || wq.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("idle_timeout", {63'd0, busy_m}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s_ready"}, {63'd0, s_ready_m}, 64'd0);
        chk({tag, "_we"}, {63'd0, we_m}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_m}, 64'd0);
        chk({tag, "_done"}, {63'd0, done_m}, 64'd0);
        chk({tag, "_hdr_error"}, {63'd0, hdr_error_m}, 64'd0);
        chk({tag, "_ovf_error"}, {63'd0, ovf_error_m}, 64'd0);
        chk({tag, "_byte_cnt"}, {48'd0, byte_cnt_m}, 64'd0);
        chk({tag, "_wr_data"}, wr_data_m, 64'd0);
        chk({tag, "_shift"}, {61'd0, shm1_m}, 64'd0);
    endtask

    initial begin
        int w;
        int d0;
        int wc0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; check_zero("reset_a");
        sel = 1'b1; check_zero("reset_b");
        sel = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: header + body 01..0A, two writes then done
        d0 = done_cnt;
        wq.push_back('{data: 64'h0807060504030201, len: 3'd7});
        wq.push_back('{data: 64'h0000000000000A09, len: 3'd1});
        pulse_start();
        chk("t1_busy_after_start", {63'd0, busy_m}, 64'd1);
        for (int i = 0; i < 8; i++) send(hdr[i], 1'b0, w);
        for (int i = 1; i <= 10; i++) send(8'(i), (i == 10), w);
        wait_idle();
        chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t1_byte_cnt", {48'd0, byte_cnt_m}, 64'd10);
        chk("t1_busy", {63'd0, busy_m}, 64'd0);
        chk("t1_hdr_error", {63'd0, hdr_error_m}, 64'd0);

        // 2: header byte 3 wrong, 4 more bytes drained, last on the 4th
        d0 = done_cnt;
        pulse_start();
        send(8'h00, 1'b0, w);
        send(8'h61, 1'b0, w);
        send(8'h73, 1'b0, w);
        send(8'h6E, 1'b0, w);
        chk("t2_hdr_error_set", {63'd0, hdr_error_m}, 64'd1);
        chk("t2_busy_in_err", {63'd0, busy_m}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            send(8'h55, (i == 3), w);
            chk("t2_s_ready_no_wait", 64'(w), 64'd0);
        end
        wait_idle();
        chk("t2_hdr_error_sticky", {63'd0, hdr_error_m}, 64'd1);
        chk("t2_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t2_s_ready_idle", {63'd0, s_ready_m}, 64'd0);

        // 3: header only, s_last on byte 8
        d0 = done_cnt;
        wc0 = wr_cnt;
        pulse_start();
        chk("t3_hdr_error_cleared", {63'd0, hdr_error_m}, 64'd0);
        for (int i = 0; i < 8; i++) send(hdr[i], (i == 7), w);
        wait_idle();
        chk("t3_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t3_no_write", 64'(wr_cnt - wc0), 64'd0);
        chk("t3_byte_cnt", {48'd0, byte_cnt_m}, 64'd0);

        // 4: MAX_BYTES=8 instance, 10-byte body overflows
        sel = 1'b1;
        d0 = done_cnt;
        wc0 = wr_cnt;
        wq.push_back('{data: 64'h0807060504030201, len: 3'd7});
        pulse_start();
        for (int i = 0; i < 8; i++) send(hdr[i], 1'b0, w);
        for (int i = 1; i <= 10; i++) send(8'(i), (i == 10), w);
        wait_idle();
        chk("t4_one_write", 64'(wr_cnt - wc0), 64'd1);
        chk("t4_ovf_error", {63'd0, ovf_error_m}, 64'd1);
        chk("t4_byte_cnt", {48'd0, byte_cnt_m}, 64'd8);
        chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t4_busy", {63'd0, busy_m}, 64'd0);
        sel = 1'b0;

        // 5: wr_ready held low 5 cycles during the write
        d0 = done_cnt;
        wc0 = wr_cnt;
        wr_ready = 1'b0;
        wq.push_back('{data: 64'h1817161514131211, len: 3'd7});
        pulse_start();
        for (int i = 0; i < 8; i++) send(hdr[i], 1'b0, w);
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), (i == 7), w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_we_held", {63'd0, we_m}, 64'd1);
            chk("t5_s_ready_low", {63'd0, s_ready_m}, 64'd0);
            @(posedge clk);
            #1;
        end
        chk("t5_no_write_yet", 64'(wr_cnt - wc0), 64'd0);
        wr_ready = 1'b1;
        wait_idle();
        chk("t5_one_write", 64'(wr_cnt - wc0), 64'd1);
        chk("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t5_byte_cnt", {48'd0, byte_cnt_m}, 64'd8);

        // 6: reset mid-BODY after 3 bytes, then a fresh 3-byte module
        pulse_start();
        for (int i = 0; i < 8; i++) send(hdr[i], 1'b0, w);
        for (int i = 0; i < 3; i++) send(8'hA1 + 8'(i), 1'b0, w);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("t6_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        wc0 = wr_cnt;
        wq.push_back('{data: 64'h0000000000B3B2B1, len: 3'd2});
        pulse_start();
        for (int i = 0; i < 8; i++) send(hdr[i], 1'b0, w);
        for (int i = 0; i < 3; i++) send(8'hB1 + 8'(i), (i == 2), w);
        wait_idle();
        chk("t6_one_write", 64'(wr_cnt - wc0), 64'd1);
        chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t6_byte_cnt", {48'd0, byte_cnt_m}, 64'd3);
        chk("t6_queue_empty", 64'(wq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
